// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
//   PAUSE_ENABLE     : active level of every pause/flush control line
//   REG_NONE         : register address meaning "no register"
//   WAIT_MAX_DEFAULT : default bound on memory-wait cycles before forced release
//   state_e          : controller state encoding (RUN / MEM_WAIT)
package pipe_hazard_ctrl_pkg;

    localparam logic       PAUSE_ENABLE     = 1'b1;
    localparam logic [3:0] REG_NONE         = 4'hF;
    localparam int         WAIT_MAX_DEFAULT = 15;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Per-operand load-use comparator.
// Flags a hit when the EXE-stage instruction is a load whose destination is a
// real register, and the ID-stage instruction reads that same register
// through this operand.
//   src_addr : ID-stage operand register address
//   src_use  : ID-stage instruction reads this operand
//   wb_load  : EXE-stage instruction is a load
//   wb_addr  : EXE-stage destination register
//   hit      : load-use dependency on this operand
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [3:0] src_addr,
    input  logic       src_use,
    input  logic       wb_load,
    input  logic [3:0] wb_addr,
    output logic       hit
);

    assign hit = wb_load & src_use & (wb_addr != REG_NONE) & (src_addr == wb_addr);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller.
// Produces same-cycle (Mealy) pause/flush controls for a 5-stage pipeline:
// load-use bubbles, taken-jump flushes, and instruction-memory conflicts where
// the MEM stage borrows the fetch port until the memory acknowledges (or a
// bounded wait expires).
//   clk, rst                      : clock, synchronous active-high reset
//   ID_SRC_A/B_ADDR, ID_SRC_A/B_USE : ID-stage source operands
//   EXE_LOAD, EXE_WB_ADDR         : EXE-stage load and its destination
//   EXE_JUMP                      : taken branch/jump resolved in EXE
//   MEM_IM_ACCESS, MEM_ACK        : MEM-stage instruction-memory access / completion
//   *_PAUSE, *_FLUSH              : pipeline register controls
//   TIMEOUT                       : sticky, set on a forced release
//   STALL_CNT                     : saturating count of PC_PAUSE cycles
//   STATE                         : debug view, 0 = RUN, 1 = MEM_WAIT
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ID_SRC_A_ADDR,
    input  logic        ID_SRC_A_USE,
    input  logic [3:0]  ID_SRC_B_ADDR,
    input  logic        ID_SRC_B_USE,
    input  logic        EXE_LOAD,
    input  logic [3:0]  EXE_WB_ADDR,
    input  logic        EXE_JUMP,
    input  logic        MEM_IM_ACCESS,
    input  logic        MEM_ACK,
    output logic        PC_PAUSE,
    output logic        IF_ID_PAUSE,
    output logic        IF_ID_FLUSH,
    output logic        ID_EXE_PAUSE,
    output logic        ID_EXE_FLUSH,
    output logic        EXE_MEM_PAUSE,
    output logic        MEM_WB_FLUSH,
    output logic        TIMEOUT,
    output logic [15:0] STALL_CNT,
    output logic        STATE
);

    state_e     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       timeout_set;
    logic       hit_a, hit_b, load_use;
    logic       forced;

    hazard_cmp u_cmp_a (
        .src_addr (ID_SRC_A_ADDR),
        .src_use  (ID_SRC_A_USE),
        .wb_load  (EXE_LOAD),
        .wb_addr  (EXE_WB_ADDR),
        .hit      (hit_a)
    );

    hazard_cmp u_cmp_b (
        .src_addr (ID_SRC_B_ADDR),
        .src_use  (ID_SRC_B_USE),
        .wb_load  (EXE_LOAD),
        .wb_addr  (EXE_WB_ADDR),
        .hit      (hit_b)
    );

    assign load_use = hit_a | hit_b;

    // wait_cnt holds the number of completed, unreleased wait cycles, so the
    // WAIT_MAX-th cycle spent in MEM_WAIT is the forced release cycle.
    assign forced = (wait_cnt == 4'(WAIT_MAX - 1));

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_set   = 1'b0;
        PC_PAUSE      = 1'b0;
        IF_ID_PAUSE   = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EXE_PAUSE  = 1'b0;
        ID_EXE_FLUSH  = 1'b0;
        EXE_MEM_PAUSE = 1'b0;
        MEM_WB_FLUSH  = 1'b0;

        case (state)
            ST_RUN: begin
                // The memory conflict wins; a coincident jump or load-use is
                // still sitting in EXE/ID when the wait ends and is served then.
                if (MEM_IM_ACCESS) begin
                    PC_PAUSE      = PAUSE_ENABLE;
                    IF_ID_FLUSH   = PAUSE_ENABLE;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = 4'd0;
                end else if (EXE_JUMP) begin
                    IF_ID_FLUSH  = PAUSE_ENABLE;
                    ID_EXE_FLUSH = PAUSE_ENABLE;
                end else if (load_use) begin
                    PC_PAUSE     = PAUSE_ENABLE;
                    IF_ID_PAUSE  = PAUSE_ENABLE;
                    ID_EXE_FLUSH = PAUSE_ENABLE;
                end
            end
            ST_MEM_WAIT: begin
                if (MEM_ACK || forced) begin
                    state_next  = ST_RUN;
                    timeout_set = !MEM_ACK;
                    if (EXE_JUMP) begin
                        IF_ID_FLUSH  = PAUSE_ENABLE;
                        ID_EXE_FLUSH = PAUSE_ENABLE;
                    end else if (load_use) begin
                        PC_PAUSE     = PAUSE_ENABLE;
                        IF_ID_PAUSE  = PAUSE_ENABLE;
                        ID_EXE_FLUSH = PAUSE_ENABLE;
                    end else begin
                        // Fetch port is still busy with the memory access
                        // during this cycle, so the fetched slot is dropped.
                        PC_PAUSE    = PAUSE_ENABLE;
                        IF_ID_FLUSH = PAUSE_ENABLE;
                    end
                end else begin
                    PC_PAUSE      = PAUSE_ENABLE;
                    IF_ID_PAUSE   = PAUSE_ENABLE;
                    ID_EXE_PAUSE  = PAUSE_ENABLE;
                    EXE_MEM_PAUSE = PAUSE_ENABLE;
                    MEM_WB_FLUSH  = PAUSE_ENABLE;
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            default: state_next = ST_RUN;
        endcase

        if (rst) begin
            PC_PAUSE      = 1'b0;
            IF_ID_PAUSE   = 1'b0;
            IF_ID_FLUSH   = 1'b0;
            ID_EXE_PAUSE  = 1'b0;
            ID_EXE_FLUSH  = 1'b0;
            EXE_MEM_PAUSE = 1'b0;
            MEM_WB_FLUSH  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= 4'd0;
            TIMEOUT   <= 1'b0;
            STALL_CNT <= 16'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_set) begin
                TIMEOUT <= 1'b1;
            end
            if (PC_PAUSE == PAUSE_ENABLE && STALL_CNT != 16'hFFFF) begin
                STALL_CNT <= STALL_CNT + 16'd1;
            end
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// Output vector order: {PC, IF_ID_P, IF_ID_F, ID_EXE_P, ID_EXE_F, EXE_MEM_P, MEM_WB_F}.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  ID_SRC_A_ADDR, ID_SRC_B_ADDR, EXE_WB_ADDR;
    logic        ID_SRC_A_USE, ID_SRC_B_USE, EXE_LOAD, EXE_JUMP, MEM_IM_ACCESS, MEM_ACK;
    logic        PC_PAUSE, IF_ID_PAUSE, IF_ID_FLUSH, ID_EXE_PAUSE, ID_EXE_FLUSH;
    logic        EXE_MEM_PAUSE, MEM_WB_FLUSH, TIMEOUT, STATE;
    logic [15:0] STALL_CNT;

    localparam logic [6:0] V_NONE = 7'b0000000;
    localparam logic [6:0] V_MEMIN = 7'b1010000;
    localparam logic [6:0] V_JUMP = 7'b0010100;
    localparam logic [6:0] V_LU = 7'b1100100;
    localparam logic [6:0] V_WAIT = 7'b1101011;
    localparam logic [6:0] V_REL = 7'b1010000;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    pipe_hazard_ctrl #(.WAIT_MAX(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_SRC_A_ADDR (ID_SRC_A_ADDR),
        .ID_SRC_A_USE  (ID_SRC_A_USE),
        .ID_SRC_B_ADDR (ID_SRC_B_ADDR),
        .ID_SRC_B_USE  (ID_SRC_B_USE),
        .EXE_LOAD      (EXE_LOAD),
        .EXE_WB_ADDR   (EXE_WB_ADDR),
        .EXE_JUMP      (EXE_JUMP),
        .MEM_IM_ACCESS (MEM_IM_ACCESS),
        .MEM_ACK       (MEM_ACK),
        .PC_PAUSE      (PC_PAUSE),
        .IF_ID_PAUSE   (IF_ID_PAUSE),
        .IF_ID_FLUSH   (IF_ID_FLUSH),
        .ID_EXE_PAUSE  (ID_EXE_PAUSE),
        .ID_EXE_FLUSH  (ID_EXE_FLUSH),
        .EXE_MEM_PAUSE (EXE_MEM_PAUSE),
        .MEM_WB_FLUSH  (MEM_WB_FLUSH),
        .TIMEOUT       (TIMEOUT),
        .STALL_CNT     (STALL_CNT),
        .STATE         (STATE)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle();
        ID_SRC_A_ADDR = 4'd0;  ID_SRC_A_USE = 1'b0;
        ID_SRC_B_ADDR = 4'd0;  ID_SRC_B_USE = 1'b0;
        EXE_LOAD = 1'b0;       EXE_WB_ADDR = 4'hF;
        EXE_JUMP = 1'b0;       MEM_IM_ACCESS = 1'b0;
        MEM_ACK = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle();
        rst = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lu_a(input logic [3:0] r);
        ID_SRC_A_ADDR = r; ID_SRC_A_USE = 1'b1; EXE_LOAD = 1'b1; EXE_WB_ADDR = r;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
    endtask

    // Scoreboard
    task automatic check_vec(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        logic [6:0] want;
        exp_q.push_back(exp);
        obs = {PC_PAUSE, IF_ID_PAUSE, IF_ID_FLUSH, ID_EXE_PAUSE, ID_EXE_FLUSH,
               EXE_MEM_PAUSE, MEM_WB_FLUSH};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
        checks++;
        assert (!(IF_ID_PAUSE && IF_ID_FLUSH) && !(ID_EXE_PAUSE && ID_EXE_FLUSH)) else begin
            errors++;
            $error("FAIL %s_pause_flush_overlap: observed %b expected no overlap", tag, obs);
        end
    endtask

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // Reset: outputs gated even with events present
        @(negedge clk);
        MEM_IM_ACCESS = 1'b1; EXE_JUMP = 1'b1;
        settle();
        check_vec("rst_gate", V_NONE);
        @(negedge clk);

        next_cycle(); settle();
        check_vec("post_rst_out", V_NONE);
        check_val("post_rst_state", 16'(STATE), 16'd0);
        check_val("post_rst_stall", STALL_CNT, 16'd0);
        check_val("post_rst_timeout", 16'(TIMEOUT), 16'd0);

        // Load-use on operand A: one bubble
        next_cycle(); set_lu_a(4'd3); settle();
        check_vec("lu_a", V_LU);
        next_cycle(); settle();
        check_vec("lu_a_after", V_NONE);
        check_val("lu_a_stall", STALL_CNT, 16'd1);

        // Load-use on operand B
        next_cycle(); ID_SRC_B_ADDR = 4'd7; ID_SRC_B_USE = 1'b1; EXE_LOAD = 1'b1; EXE_WB_ADDR = 4'd7; settle();
        check_vec("lu_b", V_LU);
        // Same address but operand not used
        next_cycle(); ID_SRC_B_ADDR = 4'd7; EXE_LOAD = 1'b1; EXE_WB_ADDR = 4'd7; settle();
        check_vec("lu_b_unused", V_NONE);
        // Matching address but not a load
        next_cycle(); ID_SRC_A_ADDR = 4'd5; ID_SRC_A_USE = 1'b1; EXE_WB_ADDR = 4'd5; settle();
        check_vec("no_load", V_NONE);
        // Destination "none" never stalls
        next_cycle(); set_lu_a(4'hF); settle();
        check_vec("lu_none", V_NONE);
        check_val("lu_none_stall", STALL_CNT, 16'd2);

        // Jump, alone and with a coincident load-use
        next_cycle(); EXE_JUMP = 1'b1; settle();
        check_vec("jump", V_JUMP);
        next_cycle(); EXE_JUMP = 1'b1; set_lu_a(4'd2); settle();
        check_vec("jump_over_lu", V_JUMP);
        // ACK ignored in RUN
        next_cycle(); MEM_ACK = 1'b1; settle();
        check_vec("ack_in_run", V_NONE);
        next_cycle(); settle();
        check_val("ack_in_run_state", 16'(STATE), 16'd0);
        check_val("jump_stall", STALL_CNT, 16'd2);

        // Memory wait released by ACK on cycle 3
        do_reset();
        next_cycle(); MEM_IM_ACCESS = 1'b1; settle();
        check_vec("mw_c0", V_MEMIN);
        check_val("mw_c0_state", 16'(STATE), 16'd0);
        next_cycle(); settle();
        check_vec("mw_c1", V_WAIT);
        check_val("mw_c1_state", 16'(STATE), 16'd1);
        next_cycle(); set_lu_a(4'd4); MEM_IM_ACCESS = 1'b1; settle();
        check_vec("mw_c2", V_WAIT);
        next_cycle(); MEM_ACK = 1'b1; settle();
        check_vec("mw_c3_release", V_REL);
        check_val("mw_c3_state", 16'(STATE), 16'd1);
        next_cycle(); settle();
        check_vec("mw_c4", V_NONE);
        check_val("mw_c4_state", 16'(STATE), 16'd0);
        check_val("mw_stall", STALL_CNT, 16'd4);
        check_val("mw_timeout", 16'(TIMEOUT), 16'd0);

        // Jump deferred across memory wait
        do_reset();
        next_cycle(); MEM_IM_ACCESS = 1'b1; EXE_JUMP = 1'b1; settle();
        check_vec("dj_c0", V_MEMIN);
        next_cycle(); EXE_JUMP = 1'b1; settle();
        check_vec("dj_c1", V_WAIT);
        next_cycle(); EXE_JUMP = 1'b1; MEM_ACK = 1'b1; settle();
        check_vec("dj_release", V_JUMP);
        next_cycle(); settle();
        check_val("dj_state", 16'(STATE), 16'd0);
        check_val("dj_stall", STALL_CNT, 16'd2);

        // Load-use served on the release cycle
        do_reset();
        next_cycle(); MEM_IM_ACCESS = 1'b1; settle();
        next_cycle(); MEM_ACK = 1'b1; set_lu_a(4'd9); settle();
        check_vec("lu_release", V_LU);
        next_cycle(); settle();
        check_val("lu_release_state", 16'(STATE), 16'd0);
        check_val("lu_release_stall", STALL_CNT, 16'd2);

        // Forced release on the 15th wait cycle
        do_reset();
        next_cycle(); MEM_IM_ACCESS = 1'b1; settle();
        for (int c = 1; c <= 14; c++) begin
            next_cycle(); settle();
            check_vec($sformatf("to_wait%0d", c), V_WAIT);
        end
        check_val("to_c14_timeout", 16'(TIMEOUT), 16'd0);
        next_cycle(); settle();
        check_vec("to_release", V_REL);
        check_val("to_release_state", 16'(STATE), 16'd1);
        next_cycle(); settle();
        check_vec("to_after", V_NONE);
        check_val("to_after_state", 16'(STATE), 16'd0);
        check_val("to_flag", 16'(TIMEOUT), 16'd1);
        check_val("to_stall", STALL_CNT, 16'd16);
        // Sticky across a normal ACK-released wait
        next_cycle(); MEM_IM_ACCESS = 1'b1; settle();
        next_cycle(); MEM_ACK = 1'b1; settle();
        next_cycle(); settle();
        check_val("to_sticky", 16'(TIMEOUT), 16'd1);

        // Reset mid-wait abandons it
        next_cycle(); MEM_IM_ACCESS = 1'b1; settle();
        next_cycle(); settle();
        check_vec("rw_wait", V_WAIT);
        next_cycle(); rst = 1'b1; settle();
        check_vec("rw_in_rst", V_NONE);
        next_cycle(); settle();
        check_vec("rw_after", V_NONE);
        check_val("rw_state", 16'(STATE), 16'd0);
        check_val("rw_timeout", 16'(TIMEOUT), 16'd0);
        check_val("rw_stall", STALL_CNT, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
